// File: rtl/sonic_pkg.sv
// sonic_pkg: constants and helpers shared by the acoustic array blocks.
//   SPEED_OF_SOUND  speed of sound, mm/s
//   ELEMENT_SPACING receiver pitch, mm
//   SIN_WIDTH       steering sine magnitude width; SIN_FULL_SCALE encodes 1.0
//   sample_t        signed receiver sample
//   steer_delay()   per-receiver steering delay in samples, clamped
package sonic_pkg;

  localparam int SPEED_OF_SOUND  = 343000;
  localparam int ELEMENT_SPACING = 9;
  localparam int SIN_WIDTH       = 17;
  localparam int SIN_FULL_SCALE  = 1 << (SIN_WIDTH - 1);
  localparam int SAMPLE_WIDTH    = 16;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // (dpr * k * sin) >> (sin_w-1), clamped to max_d. 64-bit product so the
  // largest array/sine combination cannot overflow before the shift.
  function automatic int unsigned steer_delay(input int unsigned dpr,
                                              input int unsigned k,
                                              input int unsigned sin_mag,
                                              input int unsigned sin_w,
                                              input int unsigned max_d);
    logic [63:0] p;
    p = (64'(dpr) * 64'(k) * 64'(sin_mag)) >> (sin_w - 1);
    if (p > 64'(max_d)) steer_delay = max_d;
    else                steer_delay = p[31:0];
  endfunction

endpackage

// File: rtl/delay_line.sv
// delay_line: single-channel ring buffer with registered read.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, one cycle after raddr_i
// Reading the address being written returns the new data (write-first),
// which is how a zero steering delay passes the current sample through.
module delay_line #(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (we_i && (raddr_i == waddr_i)) rdata_q <= wdata_i;
    else                              rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/receive_beamformer.sv
// receive_beamformer: delay-and-sum receive beamformer for a linear array.
//   clk_in           clock
//   rst_in           synchronous active-high reset
//   sample_valid_in  one new sample on every channel this cycle
//   samples_in       signed samples, channel 0 = leftmost
//   sin_value        steering sine magnitude (SIN_FULL_SCALE = 1.0)
//   sign_bit         1: arrival from the left, 0: from the right
//   steer_load_in    latch steering inputs and recompute delays
//   sum_out          beamformed sum
//   sum_valid_out    sum_out valid, 2 cycles after the accepted sample
// Build option: RX_BEAMFORMER_SATURATE_EN narrows sum_out to SAMPLE_WIDTH
// and saturates; otherwise the full-precision sum is output.
module receive_beamformer #(
  parameter  int NUM_RECEIVERS   = 4,
  parameter  int ELEMENT_SPACING = sonic_pkg::ELEMENT_SPACING,
  parameter  int SPEED_OF_SOUND  = sonic_pkg::SPEED_OF_SOUND,
  parameter  int SAMPLE_RATE     = 1000000,
  parameter  int SIN_WIDTH       = sonic_pkg::SIN_WIDTH,
  parameter  int SAMPLE_WIDTH    = sonic_pkg::SAMPLE_WIDTH,
  parameter  int DELAY_DEPTH     = 128,
`ifdef RX_BEAMFORMER_SATURATE_EN
  localparam int OUT_WIDTH       = SAMPLE_WIDTH
`else
  localparam int OUT_WIDTH       = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS)
`endif
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic                                        sample_valid_in,
  input  logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0]  samples_in,
  input  logic [SIN_WIDTH-1:0]                        sin_value,
  input  logic                                        sign_bit,
  input  logic                                        steer_load_in,
  output logic signed [OUT_WIDTH-1:0]                 sum_out,
  output logic                                        sum_valid_out
);

  localparam int DW     = $clog2(DELAY_DEPTH);
  localparam int CW     = DW + 1;
  localparam int FULL_W = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS);
  localparam int DPR    = ELEMENT_SPACING * SAMPLE_RATE / SPEED_OF_SOUND;

  logic [DW-1:0]                          wr_ptr_q, wr_ptr_d;
  logic [NUM_RECEIVERS-1:0][DW-1:0]       delay_q, delay_d, delay_new;
  logic [DW-1:0]                          max_delay_q, max_delay_d, max_new;
  logic [CW-1:0]                          warm_q, warm_d;
  logic [1:0]                             vld_pipe_q, vld_pipe_d;
  logic signed [OUT_WIDTH-1:0]            sum_q, sum_d;
  logic [NUM_RECEIVERS-1:0][DW-1:0]       rd_addr;
  logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0] rd_data;
  logic signed [FULL_W-1:0]               acc;
  logic signed [OUT_WIDTH-1:0]            sat;

  for (genvar i = 0; i < NUM_RECEIVERS; i++) begin : g_ch
    // Element index counted from the side the wavefront reaches last.
    assign delay_new[i] = DW'(sonic_pkg::steer_delay(
                            DPR, sign_bit ? (NUM_RECEIVERS - 1 - i) : i,
                            32'(sin_value), SIN_WIDTH, DELAY_DEPTH - 1));
    assign rd_addr[i] = wr_ptr_q - delay_q[i];

    delay_line #(.DEPTH(DELAY_DEPTH), .WIDTH(SAMPLE_WIDTH)) u_dl (
      .clk_i   (clk_in),
      .we_i    (sample_valid_in & ~rst_in),
      .waddr_i (wr_ptr_q),
      .wdata_i (samples_in[i]),
      .raddr_i (rd_addr[i]),
      .rdata_o (rd_data[i])
    );
  end

  always_comb begin
    max_new = '0;
    for (int i = 0; i < NUM_RECEIVERS; i++)
      if (delay_new[i] > max_new) max_new = delay_new[i];
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_RECEIVERS; i++)
      acc = acc + FULL_W'($signed(rd_data[i]));
  end

`ifdef RX_BEAMFORMER_SATURATE_EN
  localparam logic signed [FULL_W-1:0] SAT_MAX = FULL_W'((1 <<< (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [FULL_W-1:0] SAT_MIN = ~SAT_MAX;
  always_comb begin
    if      (acc > SAT_MAX) sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (acc < SAT_MIN) sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                    sat = acc[OUT_WIDTH-1:0];
  end
`else
  always_comb sat = acc;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    delay_d     = delay_q;
    max_delay_d = max_delay_q;
    warm_d      = warm_q;
    vld_pipe_d  = {vld_pipe_q[0], 1'b0};
    sum_d       = sum_q;
    if (sample_valid_in) begin
      wr_ptr_d = wr_ptr_q + DW'(1);
      // A sample is only emitted once every tap it reads has been written
      // since the delays were loaded.
      vld_pipe_d[0] = (warm_q > CW'(max_delay_q));
      if (warm_q != CW'(DELAY_DEPTH)) warm_d = warm_q + CW'(1);
    end
    // Load after the sample logic: a coincident sample already used the old
    // delays for its read and is not counted toward the new warm-up.
    if (steer_load_in) begin
      delay_d     = delay_new;
      max_delay_d = max_new;
      warm_d      = '0;
    end
    if (vld_pipe_q[0]) sum_d = sat;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      delay_q     <= '0;
      max_delay_q <= '0;
      warm_q      <= '0;
      vld_pipe_q  <= '0;
      sum_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      max_delay_q <= max_delay_d;
      warm_q      <= warm_d;
      vld_pipe_q  <= vld_pipe_d;
      sum_q       <= sum_d;
    end
  end

  assign sum_out       = sum_q;
  assign sum_valid_out = vld_pipe_q[1];

endmodule

// File: tb/tb_receive_beamformer.sv
// tb_receive_beamformer: directed test of receive_beamformer with default
// parameters (4 channels, 26 samples per element, depth 128).
module tb_receive_beamformer;

  localparam int N  = 4;
  localparam int SW = 16;
`ifdef RX_BEAMFORMER_SATURATE_EN
  localparam int OW = SW;
`else
  localparam int OW = SW + 2;
`endif

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    sample_valid_in;
  logic [N-1:0][SW-1:0]    samples_in;
  logic [16:0]             sin_value;
  logic                    sign_bit;
  logic                    steer_load_in;
  logic signed [OW-1:0]    sum_out;
  logic                    sum_valid_out;

  int n_run  = 0;
  int n_fail = 0;
  logic                obs_v [$];
  logic signed [63:0]  obs_s [$];

  receive_beamformer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .samples_in      (samples_in),
    .sin_value       (sin_value),
    .sign_bit        (sign_bit),
    .steer_load_in   (steer_load_in),
    .sum_out         (sum_out),
    .sum_valid_out   (sum_valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive, then log the outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [N-1:0][SW-1:0] s);
    sample_valid_in = v;
    samples_in      = s;
    @(posedge clk_in);
    #1;
    obs_v.push_back(sum_valid_out);
    obs_s.push_back(64'($signed(sum_out)));
    sample_valid_in = 1'b0;
    steer_load_in   = 1'b0;
    rst_in          = 1'b0;
  endtask

  function automatic logic [N-1:0][SW-1:0] rep(input int v);
    sonic_pkg::sample_t x;
    x = sonic_pkg::sample_t'(v);
    return {N{x}};
  endfunction

  task automatic chk_out(input string tag, input int idx, input bit ev, input int es);
    chk({tag, " vld"}, 64'(obs_v[idx]), 64'(ev));
    if (ev) chk({tag, " sum"}, obs_s[idx], 64'(es));
  endtask

  task automatic load(input int s, input bit sg);
    sin_value     = 17'(s);
    sign_bit      = sg;
    steer_load_in = 1'b1;
    step(1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int d2 [N] = '{0, 13, 26, 39};
    logic [N-1:0][SW-1:0] s;
    int e;
    int hi, lo;

    rst_in = 1'b1; sample_valid_in = 1'b0; steer_load_in = 1'b0;
    sin_value = '0; sign_bit = 1'b0; samples_in = '0;
    rst_in = 1'b1; step(1'b0, '0);
    rst_in = 1'b1; step(1'b0, '0);
    chk("reset vld", 64'(obs_v[obs_v.size()-1]), 64'(0));
    chk("reset sum", obs_s[obs_s.size()-1], 64'(0));

    // Broadside: zero delays, output = 4x input after a 1-sample warm-up.
    load(0, 1'b0);
    base = obs_v.size();
    for (int j = 0; j < 8; j++) step(1'b1, rep(j + 1));
    step(1'b0, '0);
    step(1'b0, '0);
    for (int j = 0; j < 8; j++)
      chk_out($sformatf("ramp j=%0d", j), base + j + 1, j != 0, 4 * (j + 1));
    chk_out("ramp idle", base + 9, 1'b0, 0);

    // sin = 0.5 from the right: delays 0/13/26/39. Common impulse at 40
    // spreads into four 100s; a pre-skewed impulse lands as one 400 at 129.
    load(sonic_pkg::SIN_FULL_SCALE / 2, 1'b0);
    base = obs_v.size();
    for (int j = 0; j < 136; j++) begin
      s = '0;
      for (int i = 0; i < N; i++)
        if (j == 40 || j == 129 - d2[i]) s[i] = 16'd100;
      step(1'b1, s);
    end
    step(1'b0, '0);
    for (int j = 0; j < 136; j++) begin
      e = (j == 40 || j == 53 || j == 66 || j == 79) ? 100 :
          (j == 129) ? 400 : 0;
      chk_out($sformatf("steer05 j=%0d", j), base + j + 1, j >= 40, e);
    end

    // sin = 1.0 from the left: delays 78/52/26/0, 79 suppressed samples.
    // At j=85 a coincident reload to sin=0 uses the old delays for that
    // sample, then warm-up restarts (j=86 suppressed).
    load(sonic_pkg::SIN_FULL_SCALE, 1'b1);
    base = obs_v.size();
    for (int j = 0; j < 89; j++) begin
      if (j == 85) begin
        sin_value = '0; sign_bit = 1'b0; steer_load_in = 1'b1;
      end
      step(1'b1, rep(j + 1));
    end
    step(1'b0, '0);
    for (int j = 0; j < 89; j++) begin
      e = (j <= 85) ? 4 * (j + 1) - 156 : 4 * (j + 1);
      chk_out($sformatf("steer10 j=%0d", j), base + j + 1, (j >= 79) && (j != 86), e);
    end

    // Full-scale inputs: full precision or saturated.
`ifdef RX_BEAMFORMER_SATURATE_EN
    hi = 32767;  lo = -32768;
`else
    hi = 120000; lo = -120000;
`endif
    base = obs_v.size();
    step(1'b1, rep(30000));
    step(1'b1, rep(-30000));
    step(1'b0, '0);
    chk_out("big pos", base + 1, 1'b1, hi);
    chk_out("big neg", base + 2, 1'b1, lo);

    // Mid-stream reset: in-flight sums dropped, warm-up restarts.
    base = obs_v.size();
    step(1'b1, rep(7));
    step(1'b1, rep(7));
    step(1'b1, rep(7));
    rst_in = 1'b1;
    step(1'b1, rep(7));
    step(1'b1, rep(7));
    step(1'b1, rep(7));
    step(1'b1, rep(7));
    step(1'b0, '0);
    step(1'b0, '0);
    chk_out("prerst", base + 2, 1'b1, 28);
    chk_out("rst next", base + 3, 1'b0, 0);
    chk("rst next sum", obs_s[base + 3], 64'(0));
    chk_out("rst +1", base + 4, 1'b0, 0);
    chk_out("rst +2", base + 5, 1'b0, 0);
    chk_out("rst +3", base + 6, 1'b1, 28);
    chk_out("rst +4", base + 7, 1'b1, 28);
    chk_out("rst idle", base + 8, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/receive_beamformer.md
RECEIVE_BEAMFORMER -- requirements
Module: receive_beamformer

Interface
REQ-001 SHALL have parameter NUM_RECEIVERS, default 4, giving the number of receiver channels in the linear array, indexed left to right.
REQ-002 SHALL have parameter ELEMENT_SPACING, default 9, giving the receiver pitch in mm.
REQ-003 SHALL have parameter SPEED_OF_SOUND, default 343000, giving the speed of sound in mm/s.
REQ-004 SHALL have parameter SAMPLE_RATE, default 1000000, giving the per-channel sample rate in Hz.
REQ-005 SHALL have parameter SIN_WIDTH, default 17, giving the sine magnitude width, where 2^(SIN_WIDTH-1) represents 1.0.
REQ-006 SHALL have parameter SAMPLE_WIDTH, default 16, giving the signed two's-complement sample width.
REQ-007 SHALL have parameter DELAY_DEPTH, default 128, giving the power-of-two delay-line length in samples.
REQ-008 SHALL have port clk_in, input, 1 bit: the system clock; single clock domain.
REQ-009 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port sample_valid_in, input, 1 bit: one new sample on every channel this cycle.
REQ-011 SHALL have port samples_in, input, NUM_RECEIVERS x SAMPLE_WIDTH bits: signed samples, one per channel.
REQ-012 SHALL have port sin_value, input, SIN_WIDTH bits: steering sine magnitude.
REQ-013 SHALL have port sign_bit, input, 1 bit: 1 means arrival from the left, 0 means arrival from the right.
REQ-014 SHALL have port steer_load_in, input, 1 bit: latch sin_value and sign_bit and recompute the delays.
REQ-015 SHALL have port sum_out, output, OUT_WIDTH bits: signed beamformed sum.
REQ-016 SHALL have port sum_valid_out, output, 1 bit: sum_out is valid this cycle (single-cycle pulse).

Function
REQ-017 SHALL define DELAY_PER_RECEIVER as ELEMENT_SPACING*SAMPLE_RATE/SPEED_OF_SOUND using integer division, so the default value is 26.
REQ-018 SHALL, on steer_load_in, register delay[i] = (DELAY_PER_RECEIVER*k*sin_value) >> (SIN_WIDTH-1), where k = i if sign_bit=0 and k = NUM_RECEIVERS-1-i if sign_bit=1; this matches the transmit-side steering convention.
REQ-019 SHALL clamp any computed delay greater than DELAY_DEPTH-1 to DELAY_DEPTH-1.
REQ-020 SHALL write each channel's sample into its ring buffer at a shared write pointer on sample_valid_in; the pointer wraps modulo DELAY_DEPTH.
REQ-021 SHALL read channel i at address (wr_ptr - delay[i]) mod DELAY_DEPTH, where delay 0 returns the sample written in the same cycle.
REQ-022 SHALL sign-extend all channel outputs and sum them; full-precision OUT_WIDTH = SAMPLE_WIDTH + clog2(NUM_RECEIVERS).
REQ-023 SHALL assert sum_valid_out exactly 2 cycles after an accepted sample_valid_in; it SHALL never assert without a corresponding input sample.
REQ-024 SHALL maintain a warm-up counter of samples written since reset or the last steer load; sum_valid_out SHALL be suppressed while the counter is less than or equal to the maximum latched delay; the counter saturates at DELAY_DEPTH.
REQ-025 SHALL, when steer_load_in and sample_valid_in coincide, write and sum that sample using the old delays, load the new delays, and clear the warm-up counter to 0 with that sample not counted.
REQ-026 SHALL continue accepting samples on back-to-back sample_valid_in cycles with no stall (full throughput).

Reset
REQ-027 SHALL, on rst_in, clear wr_ptr, all delays, the warm-up counter, and the pipeline valids to 0, and drive sum_out to 0 and sum_valid_out to 0 on the next edge.
REQ-028 SHALL treat a mid-stream reset as discarding all in-flight sums; buffer contents are not cleared and are masked by warm-up.

Configuration
REQ-029 SHALL, when RX_BEAMFORMER_SATURATE_EN is defined, set OUT_WIDTH = SAMPLE_WIDTH and clamp the sum to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; when it is undefined, output the full-precision sum with no clamping.

Structure
REQ-030 SHALL place SPEED_OF_SOUND, ELEMENT_SPACING, SIN_WIDTH, the sin full-scale constant, and the sample typedef in shared package sonic_pkg.
REQ-031 SHALL implement the per-channel ring buffer as sub-module delay_line, with write port, read address, and registered read data, instantiated NUM_RECEIVERS times.

Verification
REQ-032 SHALL cover: sin=0, all channels fed ramp 1,2,3... -> after warm-up, sum_out = 4x the input sample, 2 cycles later.
REQ-033 SHALL cover: sin=0x8000, sign=0, impulse 100 on all channels -> channel delays 0/13/26/39; four pulses of 100 appear at the output, and the aligned-steering impulse timed per delay yields a single 400.
REQ-034 SHALL cover: sin=0x10000, sign=1 -> delays 78/52/26/0; sum_valid_out stays low for the first 79 samples.
REQ-035 SHALL cover: steer_load_in coincident with sample_valid_in -> that sample uses the old delays and the warm-up restarts.
REQ-036 SHALL cover: with RX_BEAMFORMER_SATURATE_EN defined, all channels at 30000 -> sum_out = 32767; all channels at -30000 -> sum_out = -32768; without the macro -> 120000 and -120000.
REQ-037 SHALL cover: rst_in asserted mid-stream -> sum_valid_out = 0 next cycle, and no stale valid appears afterward.
